// File: rtl/shared_vram_arbiter.sv
// CPU A / CPU B arbiter for the shared VRAM and work RAM: drives AB_Sel, the WAITn stalls and BUSY.
// Optional ownership watchdog is enabled with `define ARB_TIMEOUT_EN (otherwise ARB_TOUTn is tied high).
module shared_vram_arbiter #(
    parameter int unsigned SETTLE_CYC  = 1,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic RESETn,
    input  logic A_REQn,
    input  logic B_REQn,
    output logic AB_Sel,
    output logic A_WAITn,
    output logic B_WAITn,
    output logic BUSY,
    output logic ARB_TOUTn
);

    typedef enum logic [1:0] {
        IDLE,
        TURN,
        OWN_A,
        OWN_B
    } state_t;

    localparam logic [2:0] SETTLE_LD = 3'(SETTLE_CYC);

    if (SETTLE_CYC < 1 || SETTLE_CYC > 7) begin : g_bad_settle
        $error("SETTLE_CYC must be in 1..7");
    end
    if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be in 2..65535");
    end

    state_t     state_q, state_d;
    logic       ab_sel_q, ab_sel_d;
    logic       busy_q, busy_d;
    logic       last_owner_q, last_owner_d;   // 0 = A, 1 = B
    logic       target_q, target_d;           // pending owner while in TURN
    logic [2:0] settle_q, settle_d;

    logic a_req;
    logic b_req;
    logic winner;

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] WDOG_LIMIT = 16'(TIMEOUT_CYC - 1);

    logic [15:0] wdog_q, wdog_d;
    logic        tout_n_q, tout_n_d;
`endif

    assign a_req  = ~A_REQn;
    assign b_req  = ~B_REQn;
    // On a tie the CPU that did not own the bus last goes first.
    assign winner = (a_req && b_req) ? ~last_owner_q : b_req;

    always_comb begin
        state_d      = state_q;
        ab_sel_d     = ab_sel_q;
        last_owner_d = last_owner_q;
        target_d     = target_q;
        settle_d     = settle_q;
`ifdef ARB_TIMEOUT_EN
        wdog_d       = wdog_q;
        tout_n_d     = tout_n_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (a_req || b_req) begin
                    if (winner == ab_sel_q) begin
                        state_d = winner ? OWN_B : OWN_A;
                    end else begin
                        state_d  = TURN;
                        ab_sel_d = winner;
                        target_d = winner;
                        settle_d = SETTLE_LD;
                    end
                end
            end

            TURN: begin
                if (settle_q <= 3'd1) begin
                    settle_d = '0;
                    if (target_q ? b_req : a_req) begin
                        state_d = target_q ? OWN_B : OWN_A;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    settle_d = settle_q - 3'd1;
                end
            end

            OWN_A: begin
                if (!a_req) begin
                    if (b_req) begin
                        state_d  = TURN;
                        ab_sel_d = 1'b1;
                        target_d = 1'b1;
                        settle_d = SETTLE_LD;
                    end else begin
                        state_d = IDLE;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (b_req && wdog_q == WDOG_LIMIT) begin
                    state_d      = TURN;
                    ab_sel_d     = 1'b1;
                    target_d     = 1'b1;
                    settle_d     = SETTLE_LD;
                    last_owner_d = 1'b0;
                    tout_n_d     = 1'b0;
                end
`endif
            end

            OWN_B: begin
                if (!b_req) begin
                    if (a_req) begin
                        state_d  = TURN;
                        ab_sel_d = 1'b0;
                        target_d = 1'b0;
                        settle_d = SETTLE_LD;
                    end else begin
                        state_d = IDLE;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (a_req && wdog_q == WDOG_LIMIT) begin
                    state_d      = TURN;
                    ab_sel_d     = 1'b0;
                    target_d     = 1'b0;
                    settle_d     = SETTLE_LD;
                    last_owner_d = 1'b1;
                    tout_n_d     = 1'b0;
                end
`endif
            end

            default: state_d = IDLE;
        endcase

        if (state_d == OWN_A && state_q != OWN_A) begin
            last_owner_d = 1'b0;
        end
        if (state_d == OWN_B && state_q != OWN_B) begin
            last_owner_d = 1'b1;
        end

        busy_d = (state_d == OWN_A) || (state_d == OWN_B);

`ifdef ARB_TIMEOUT_EN
        // Only contended ownership cycles count; any state change restarts the count.
        if (state_d != state_q) begin
            wdog_d = '0;
        end else if ((state_q == OWN_A && b_req) || (state_q == OWN_B && a_req)) begin
            wdog_d = wdog_q + 16'd1;
        end
`endif
    end

    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            state_q      <= IDLE;
            ab_sel_q     <= 1'b0;
            busy_q       <= 1'b0;
            last_owner_q <= 1'b1;
            target_q     <= 1'b0;
            settle_q     <= '0;
`ifdef ARB_TIMEOUT_EN
            wdog_q       <= '0;
            tout_n_q     <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            ab_sel_q     <= ab_sel_d;
            busy_q       <= busy_d;
            last_owner_q <= last_owner_d;
            target_q     <= target_d;
            settle_q     <= settle_d;
`ifdef ARB_TIMEOUT_EN
            wdog_q       <= wdog_d;
            tout_n_q     <= tout_n_d;
`endif
        end
    end

    assign AB_Sel  = ab_sel_q;
    assign BUSY    = busy_q;
    assign A_WAITn = ~RESETn | ~(a_req && state_q != OWN_A);
    assign B_WAITn = ~RESETn | ~(b_req && state_q != OWN_B);

`ifdef ARB_TIMEOUT_EN
    assign ARB_TOUTn = tout_n_q;
`else
    assign ARB_TOUTn = 1'b1;
`endif

endmodule

// File: tb/tb_shared_vram_arbiter.sv
// Directed-vector bench for shared_vram_arbiter (SETTLE_CYC=1, TIMEOUT_CYC=8).
// Vector layout: {A_REQn, B_REQn, AB_Sel, A_WAITn, B_WAITn, BUSY}, inputs held for one clk cycle.
module tb_shared_vram_arbiter;

    logic clk;
    logic RESETn;
    logic A_REQn;
    logic B_REQn;
    logic AB_Sel;
    logic A_WAITn;
    logic B_WAITn;
    logic BUSY;
    logic ARB_TOUTn;

    int checks   = 0;
    int failures = 0;

    shared_vram_arbiter #(
        .SETTLE_CYC (1),
        .TIMEOUT_CYC(8)
    ) dut (
        .clk      (clk),
        .RESETn   (RESETn),
        .A_REQn   (A_REQn),
        .B_REQn   (B_REQn),
        .AB_Sel   (AB_Sel),
        .A_WAITn  (A_WAITn),
        .B_WAITn  (B_WAITn),
        .BUSY     (BUSY),
        .ARB_TOUTn(ARB_TOUTn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs just after a rising edge, then stop at the falling edge to sample.
    task automatic cyc(input logic a_n, input logic b_n);
        @(posedge clk);
        #1;
        A_REQn = a_n;
        B_REQn = b_n;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        RESETn = 1'b0;
        A_REQn = 1'b1;
        B_REQn = 1'b1;
        repeat (2) @(negedge clk);
        RESETn = 1'b1;
    endtask

    task automatic test_reset();
        logic [4:0] obs;
        RESETn = 1'b0;
        A_REQn = 1'b0;
        B_REQn = 1'b0;
        repeat (2) @(negedge clk);
        obs = {AB_Sel, A_WAITn, B_WAITn, BUSY, ARB_TOUTn};
        checks++;
        if (obs !== 5'b01101) begin
            failures++;
            $display("FAIL reset_hold {sel,awn,bwn,busy,tout} got=%b exp=%b", obs, 5'b01101);
        end
        A_REQn = 1'b1;
        B_REQn = 1'b1;
        RESETn = 1'b1;
        cyc(1'b1, 1'b1);
        obs = {AB_Sel, A_WAITn, B_WAITn, BUSY, ARB_TOUTn};
        checks++;
        if (obs !== 5'b01101) begin
            failures++;
            $display("FAIL reset_idle {sel,awn,bwn,busy,tout} got=%b exp=%b", obs, 5'b01101);
        end
    endtask

    task automatic test_single_a();
        logic [5:0] v [6];
        logic [3:0] obs;
        v = '{6'b01_0010, 6'b01_0111, 6'b01_0111, 6'b01_0111, 6'b11_0111, 6'b11_0110};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cyc(v[i][5], v[i][4]);
            obs = {AB_Sel, A_WAITn, B_WAITn, BUSY};
            checks++;
            if (obs !== v[i][3:0]) begin
                failures++;
                $display("FAIL single_a cyc%0d {sel,awn,bwn,busy} got=%b exp=%b", i, obs, v[i][3:0]);
            end
        end
    endtask

    task automatic test_single_b();
        logic [5:0] v [5];
        logic [3:0] obs;
        v = '{6'b10_0100, 6'b10_1100, 6'b10_1111, 6'b11_1111, 6'b11_1110};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(v[i][5], v[i][4]);
            obs = {AB_Sel, A_WAITn, B_WAITn, BUSY};
            checks++;
            if (obs !== v[i][3:0]) begin
                failures++;
                $display("FAIL single_b cyc%0d {sel,awn,bwn,busy} got=%b exp=%b", i, obs, v[i][3:0]);
            end
        end
    endtask

    // First tie goes to A; after A owned it, the next tie goes to B and A waits through B's release + TURN.
    task automatic test_contention();
        logic [5:0] v [12];
        logic [3:0] obs;
        v = '{6'b00_0000, 6'b00_0101, 6'b11_0111, 6'b11_0110,
              6'b00_0000, 6'b00_1000, 6'b00_1011, 6'b01_1011,
              6'b01_0010, 6'b01_0111, 6'b11_0111, 6'b11_0110};
        do_reset();
        for (int i = 0; i < 12; i++) begin
            cyc(v[i][5], v[i][4]);
            obs = {AB_Sel, A_WAITn, B_WAITn, BUSY};
            checks++;
            if (obs !== v[i][3:0]) begin
                failures++;
                $display("FAIL contention cyc%0d {sel,awn,bwn,busy} got=%b exp=%b", i, obs, v[i][3:0]);
            end
            if (!A_REQn && !B_REQn) begin
                checks++;
                if (A_WAITn && B_WAITn) begin
                    failures++;
                    $display("FAIL contention_both_run cyc%0d waitn got=%b%b exp=not 11", i, A_WAITn, B_WAITn);
                end
            end
        end
    endtask

    // A's TURN is abandoned when A withdraws; B then gets its own TURN.
    task automatic test_withdraw();
        logic [5:0] v [13];
        logic [3:0] obs;
        v = '{6'b10_0100, 6'b10_1100, 6'b11_1111, 6'b11_1110,
              6'b01_1010, 6'b10_0100, 6'b10_0100, 6'b10_1100,
              6'b00_1011, 6'b01_1011, 6'b01_0010, 6'b11_0111, 6'b11_0110};
        do_reset();
        for (int i = 0; i < 13; i++) begin
            cyc(v[i][5], v[i][4]);
            obs = {AB_Sel, A_WAITn, B_WAITn, BUSY};
            checks++;
            if (obs !== v[i][3:0]) begin
                failures++;
                $display("FAIL withdraw cyc%0d {sel,awn,bwn,busy} got=%b exp=%b", i, obs, v[i][3:0]);
            end
            if (!A_REQn && !B_REQn) begin
                checks++;
                if (A_WAITn && B_WAITn) begin
                    failures++;
                    $display("FAIL withdraw_both_run cyc%0d waitn got=%b%b exp=not 11", i, A_WAITn, B_WAITn);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] v [3];
        logic [3:0] obs;
        v = '{6'b10_0100, 6'b10_1100, 6'b00_1011};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(v[i][5], v[i][4]);
            obs = {AB_Sel, A_WAITn, B_WAITn, BUSY};
            checks++;
            if (obs !== v[i][3:0]) begin
                failures++;
                $display("FAIL reset_mid_setup cyc%0d {sel,awn,bwn,busy} got=%b exp=%b", i, obs, v[i][3:0]);
            end
        end
        #1;
        RESETn = 1'b0;
        #1;
        obs = {AB_Sel, A_WAITn, B_WAITn, BUSY};
        checks++;
        if (obs !== 4'b0110) begin
            failures++;
            $display("FAIL reset_mid_async {sel,awn,bwn,busy} got=%b exp=%b", obs, 4'b0110);
        end
        @(posedge clk);
        #1;
        B_REQn = 1'b1;
        @(negedge clk);
        RESETn = 1'b1;
        #1;
        obs = {AB_Sel, A_WAITn, B_WAITn, BUSY};
        checks++;
        if (obs !== 4'b0010) begin
            failures++;
            $display("FAIL reset_mid_release {sel,awn,bwn,busy} got=%b exp=%b", obs, 4'b0010);
        end
        cyc(1'b0, 1'b1);
        obs = {AB_Sel, A_WAITn, B_WAITn, BUSY};
        checks++;
        if (obs !== 4'b0111) begin
            failures++;
            $display("FAIL reset_mid_grant {sel,awn,bwn,busy} got=%b exp=%b", obs, 4'b0111);
        end
    endtask

    // A holds the bus while B waits; the watchdog (if built in) hands it to B after 8 contended cycles.
    task automatic test_timeout();
        logic [5:0] v [14];
        logic [3:0] obs;
        logic       exp_t;
`ifdef ARB_TIMEOUT_EN
        v = '{6'b01_0010, 6'b00_0101, 6'b00_0101, 6'b00_0101, 6'b00_0101,
              6'b00_0101, 6'b00_0101, 6'b00_0101, 6'b00_0101, 6'b00_1000,
              6'b01_1011, 6'b01_0010, 6'b11_0111, 6'b11_0110};
`else
        v = '{6'b01_0010, 6'b00_0101, 6'b00_0101, 6'b00_0101, 6'b00_0101,
              6'b00_0101, 6'b00_0101, 6'b00_0101, 6'b00_0101, 6'b00_0101,
              6'b00_0101, 6'b00_0101, 6'b11_0111, 6'b11_0110};
`endif
        do_reset();
        for (int i = 0; i < 14; i++) begin
            cyc(v[i][5], v[i][4]);
            obs = {AB_Sel, A_WAITn, B_WAITn, BUSY};
            checks++;
            if (obs !== v[i][3:0]) begin
                failures++;
                $display("FAIL timeout cyc%0d {sel,awn,bwn,busy} got=%b exp=%b", i, obs, v[i][3:0]);
            end
`ifdef ARB_TIMEOUT_EN
            exp_t = (i >= 9) ? 1'b0 : 1'b1;
`else
            exp_t = 1'b1;
`endif
            checks++;
            if (ARB_TOUTn !== exp_t) begin
                failures++;
                $display("FAIL timeout_flag cyc%0d ARB_TOUTn got=%b exp=%b", i, ARB_TOUTn, exp_t);
            end
        end
    endtask

    initial begin
        RESETn = 1'b0;
        A_REQn = 1'b1;
        B_REQn = 1'b1;
        test_reset();
        test_single_a();
        test_single_b();
        test_contention();
        test_withdraw();
        test_reset_mid();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shared_vram_arbiter.md
Name: shared_vram_arbiter

Overview:
- Arbitrates CPU A and CPU B access to the shared video/work RAM (front, side and back1 VRAM, shared RAM).
- Drives the AB_Sel select that steers the chip-select decode PAL and the VRDn read mux.
- Stalls the losing CPU with its Z80 WAITn line until it owns the bus.
- Sits between the per-CPU address/MREQ decode and the VRAM chip-select PAL.

Parameters:
- SETTLE_CYC, 1: dead cycles inserted when AB_Sel changes (bus turnaround); legal range 1..7.
- TIMEOUT_CYC, 1024: ownership watchdog limit in clk cycles (used only with ARB_TIMEOUT_EN); legal range 2..65535.

Ports:
- clk  in  1  system clock; all CPU-side inputs are synchronous to it.
- RESETn  in  1  asynchronous active-low reset.
- A_REQn  in  1  CPU A shared-region access (MREQn low and region hit), active low.
- B_REQn  in  1  CPU B shared-region access, active low.
- AB_Sel  out  1  0 = CPU A owns the shared bus, 1 = CPU B owns it; registered.
- A_WAITn  out  1  Z80 WAIT for CPU A, active low.
- B_WAITn  out  1  Z80 WAIT for CPU B, active low.
- BUSY  out  1  a CPU currently owns the bus (state OWN_A or OWN_B); registered.
- ARB_TOUTn  out  1  sticky watchdog flag, active low.

Behaviour:
- Clock and reset: one clock, clk. RESETn is asynchronous and active-low.
- Reset values: state IDLE, AB_Sel=0, BUSY=0, last_owner=B (so A wins the first tie), settle counter=0, watchdog counter=0, ARB_TOUTn=1. While RESETn is low, A_WAITn and B_WAITn are forced to 1.
- States: IDLE, TURN, OWN_A, OWN_B. A target register records the pending owner during TURN.
- IDLE:
  - Winner selection: if one request is active, that requester wins. If both are active, the requester that is not last_owner wins.
  - Winner matches AB_Sel: go to OWN_x on the next edge.
  - Winner does not match AB_Sel: go to TURN, toggle AB_Sel on the same edge, load the settle counter with SETTLE_CYC.
  - No request: stay in IDLE; AB_Sel is parked unchanged.
- TURN:
  - Settle counter decrements every cycle.
  - When it reaches 1: go to OWN_target if the target's REQn is still low, otherwise go to IDLE. AB_Sel keeps its new value either way.
- OWN_x:
  - last_owner=x on entry; BUSY=1.
  - Stay while x's REQn is low.
  - When x's REQn goes high: if the other CPU is requesting, go directly to TURN (toggle AB_Sel, load the counter); otherwise go to IDLE.
  - No preemption while x is requesting.
- WAIT outputs (combinational from registered state and REQ inputs):
  - A_WAITn = NOT(A_REQn==0 AND state!=OWN_A).
  - B_WAITn is symmetric.
  - An idle CPU is never stalled.
- Latency:
  - Matching AB_Sel from IDLE: WAITn is low for exactly 1 cycle after REQn falls.
  - Mismatch: WAITn is low for 1+SETTLE_CYC cycles.
  - Contention: the loser waits for the owner's release, plus 0 cycles to enter TURN, plus SETTLE_CYC.
- AB_Sel changes only on the edges entering TURN; it never changes in OWN states. Both WAITn outputs are never high together while both REQn are low.
- Reset mid-operation: asynchronous return to the reset values above. A CPU request held across reset is re-arbitrated from IDLE.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit watchdog counts cycles in OWN_x while the other CPU is requesting.
  - When it reaches TIMEOUT_CYC: force TURN (toggle AB_Sel), clear last_owner fairness to the waiting CPU, and set ARB_TOUTn=0 (sticky until reset).
  - The counter clears on any state change.
- Undefined: no watchdog logic; ARB_TOUTn is tied to 1.

Test Plan:
- Reset, then A_REQn low for 4 cycles with B idle -> A_WAITn low 1 cycle, OWN_A, AB_Sel stays 0, BUSY=1 for 3 cycles, then IDLE.
- After reset, B_REQn low, SETTLE_CYC=1 -> AB_Sel toggles to 1 at edge 1, OWN_B at edge 2, B_WAITn low exactly 2 cycles, A_WAITn stays 1.
- A_REQn and B_REQn fall on the same cycle after reset -> A granted first; B waits until A releases+1+SETTLE_CYC. On the next simultaneous pair, B is granted first.
- B requests during TURN toward A, then A withdraws before settle ends -> TURN goes to IDLE with AB_Sel=0, then B is arbitrated via a new TURN. Check that no cycle has both WAITn high with both REQn low.
- Assert RESETn low while in OWN_B -> immediately AB_Sel=0, BUSY=0, both WAITn=1; after release, pending A_REQn is granted in 1 cycle.
- With ARB_TIMEOUT_EN, TIMEOUT_CYC=8, A holds REQ indefinitely while B requests -> at 8 cycles AB_Sel goes to 1, ARB_TOUTn=0 and stays 0. Without the macro, A keeps the bus and ARB_TOUTn=1.
